mcb_port_arbiter: RTL and testbench

- Shares one 32-bit Spartan-6 MCB user port (cmd/wr/rd FIFOs) between two requesters: requester 0 is the VGA line fetcher, requester 1 is the UART MCU.
- Runs each granted transaction to completion as one atomic burst:
  - Write: push data words, then issue the command.
  - Read: issue the command, then drain the read data.
- Sits between the requesters and the c3_pX_* signals of the DDR3 MIG instance. Holds off all traffic until calibration completes.

---
 rtl/mcb_arb_pkg.sv | 16 +
 rtl/mcb_port_arbiter_if.sv | 48 ++++
 rtl/mcb_arb_grant.sv | 35 +++
 rtl/mcb_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mcb_port_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mcb_arb_pkg.sv
// Shared constants for the two-requester MCB user-port arbiter:
// FSM state encoding and MCB command instructions.
package mcb_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        CMD   = 3'd2,
        RDATA = 3'd3,
        FIN   = 3'd4
    } arb_state_e;

    localparam logic [2:0] INSTR_WR = 3'b000;
    localparam logic [2:0] INSTR_RD = 3'b001;

endpackage

// File: rtl/mcb_port_arbiter_if.sv
// Requester-side and MCB-user-port-side bundles for mcb_port_arbiter.
// master drives the transaction; slave answers it.
interface mcb_req_if #(
    parameter int BL_W   = 6,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  rw;
    logic [BL_W-1:0]       bl;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_mask;
    logic                  wr_ack;
    logic                  rd_valid;
    logic                  done;

    modport master (output req, rw, bl, addr, wr_data, wr_mask,
                    input  wr_ack, rd_valid, done);
    modport slave  (input  req, rw, bl, addr, wr_data, wr_mask,
                    output wr_ack, rd_valid, done);
endinterface

interface mcb_user_port_if #(
    parameter int BL_W   = 6,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic                  cmd_en;
    logic [2:0]            cmd_instr;
    logic [BL_W-1:0]       cmd_bl;
    logic [ADDR_W-1:0]     cmd_byte_addr;
    logic                  cmd_full;
    logic                  wr_en;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_mask;
    logic                  wr_full;
    logic                  rd_en;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_empty;

    modport master (output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
                           wr_en, wr_data, wr_mask, rd_en,
                    input  cmd_full, wr_full, rd_data, rd_empty);
    modport slave  (input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
                           wr_en, wr_data, wr_mask, rd_en,
                    output cmd_full, wr_full, rd_data, rd_empty);
endinterface

// File: rtl/mcb_arb_grant.sv
// Two-way grant: fixed priority (0 over 1), or with ARB_ROUND_ROBIN_EN a
// last-owner register so a tie goes to whoever did not own the last burst.
module mcb_arb_grant (
`ifdef ARB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst_n,
    input  logic       take,
`endif
    input  logic [1:0] req,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    assign gnt_vld = |req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    always_comb begin
        gnt_idx = ~req[0];
        if (req == 2'b11) gnt_idx = ~last_q;
        last_d = last_q;
        if (take) last_d = gnt_idx;
    end

    // Resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`else
    assign gnt_idx = ~req[0];
`endif

endmodule

// File: rtl/mcb_port_arbiter.sv
// Shares one Spartan-6 MCB user port between the VGA fetcher (m0) and the
// UART MCU (m1); each grant runs as one atomic burst. Option: ARB_ROUND_ROBIN_EN.
module mcb_port_arbiter
    import mcb_arb_pkg::*;
#(
    parameter int BL_W   = 6,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              calib_done,
    mcb_req_if.slave          m0,
    mcb_req_if.slave          m1,
    mcb_user_port_if.master   p,
    output logic [DATA_W-1:0] rd_data,
    output logic              owner
);

    arb_state_e          state_q, state_d;
    logic                owner_q, owner_d;
    logic                rw_q, rw_d;
    logic [BL_W-1:0]     bl_q, bl_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BL_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [1:0]          rd_valid_q, rd_valid_d;
    logic [1:0]          wr_ack;
    logic [1:0]          done;
    logic                gnt_vld, gnt_idx;

`ifdef ARB_ROUND_ROBIN_EN
    logic take;
    assign take = (state_q == IDLE) && calib_done && gnt_vld;
`endif

    mcb_arb_grant u_grant (
`ifdef ARB_ROUND_ROBIN_EN
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .take    (take),
`endif
        .req     ({m1.req, m0.req}),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rw_d       = rw_q;
        bl_d       = bl_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        wr_ack     = '0;
        done       = '0;
        p.cmd_en   = 1'b0;
        p.wr_en    = 1'b0;
        p.rd_en    = 1'b0;

        case (state_q)
            IDLE: begin
                // calib_done only gates new grants; bursts in flight finish.
                if (calib_done && gnt_vld) begin
                    owner_d = gnt_idx;
                    rw_d    = gnt_idx ? m1.rw   : m0.rw;
                    bl_d    = gnt_idx ? m1.bl   : m0.bl;
                    addr_d  = gnt_idx ? m1.addr : m0.addr;
                    cnt_d   = '0;
                    state_d = rw_d ? CMD : WDATA;
                end
            end
            WDATA: begin
                if (!p.wr_full) begin
                    p.wr_en         = 1'b1;
                    wr_ack[owner_q] = 1'b1;
                    cnt_d           = cnt_q + 1'b1;
                    if (cnt_q == bl_q) state_d = CMD;
                end
            end
            CMD: begin
                if (!p.cmd_full) begin
                    p.cmd_en = 1'b1;
                    if (rw_q) begin
                        cnt_d   = '0;
                        state_d = RDATA;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RDATA: begin
                p.rd_en = ~p.rd_empty;
                if (!p.rd_empty) begin
                    rd_data_d           = p.rd_data;
                    rd_valid_d[owner_q] = 1'b1;
                    cnt_d               = cnt_q + 1'b1;
                    if (cnt_q == bl_q) state_d = FIN;
                end
            end
            FIN: begin
                done[owner_q] = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rw_q       <= 1'b0;
            bl_q       <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rw_q       <= rw_d;
            bl_q       <= bl_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign p.cmd_instr     = rw_q ? INSTR_RD : INSTR_WR;
    assign p.cmd_bl        = bl_q;
    assign p.cmd_byte_addr = addr_q;
    assign p.wr_data       = owner_q ? m1.wr_data : m0.wr_data;
    assign p.wr_mask       = owner_q ? m1.wr_mask : m0.wr_mask;

    assign m0.wr_ack   = wr_ack[0];
    assign m1.wr_ack   = wr_ack[1];
    assign m0.rd_valid = rd_valid_q[0];
    assign m1.rd_valid = rd_valid_q[1];
    assign m0.done     = done[0];
    assign m1.done     = done[1];

    assign rd_data = rd_data_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// Directed bench for mcb_port_arbiter: a small MCB FIFO model plus a
// requester model, per-scenario tasks with hand-computed expectations.
module tb_mcb_port_arbiter;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic calib_done = 1'b0;
    always #5 sys_clk = ~sys_clk;

    mcb_req_if       m0_if ();
    mcb_req_if       m1_if ();
    mcb_user_port_if p_if ();
    logic [31:0] rd_data;
    logic        owner;

    mcb_port_arbiter dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .calib_done (calib_done),
        .m0         (m0_if.slave),
        .m1         (m1_if.slave),
        .p          (p_if.master),
        .rd_data    (rd_data),
        .owner      (owner)
    );

    // requester drive
    logic [1:0]  req = '0, rw = '0;
    logic [5:0]  bl_v [2];
    logic [29:0] addr_v [2];
    logic [31:0] wd_v [2];
    logic [3:0]  wm_v [2];
    assign m0_if.req = req[0];       assign m1_if.req = req[1];
    assign m0_if.rw = rw[0];         assign m1_if.rw = rw[1];
    assign m0_if.bl = bl_v[0];       assign m1_if.bl = bl_v[1];
    assign m0_if.addr = addr_v[0];   assign m1_if.addr = addr_v[1];
    assign m0_if.wr_data = wd_v[0];  assign m1_if.wr_data = wd_v[1];
    assign m0_if.wr_mask = wm_v[0];  assign m1_if.wr_mask = wm_v[1];
    logic [1:0] ack, rdv, done;
    assign ack  = {m1_if.wr_ack, m0_if.wr_ack};
    assign rdv  = {m1_if.rd_valid, m0_if.rd_valid};
    assign done = {m1_if.done, m0_if.done};

    // MCB side drive
    logic        cmd_full = 1'b0, wr_full = 1'b0, rd_empty = 1'b1;
    logic [31:0] prd = '0;
    assign p_if.cmd_full = cmd_full;
    assign p_if.wr_full  = wr_full;
    assign p_if.rd_empty = rd_empty;
    assign p_if.rd_data  = prd;

    int n_run = 0, n_fail = 0;

    // per-transaction records
    int          npush, nack, nrd, ndone, ncmd, bad, other, c_npush, cyc;
    logic [31:0] wlog [64];
    logic [3:0]  mlog [64];
    logic [31:0] rlog [64];
    logic [2:0]  c_instr;
    logic [5:0]  c_bl;
    logic [29:0] c_addr;
    logic        c_owner;
    int          wr_stall_at = -1, wr_stall_len = 0, cmd_stall_len = 0;
    bit          rd_toggle = 1'b0;

    task automatic run_txn(input int n, input logic r, input logic [5:0] b,
                           input logic [29:0] a, input logic [31:0] base);
        int widx = 0, ridx = 0, wst = 0, cst = 0;
        bit cmd_seen = 1'b0;
        npush = 0; nack = 0; nrd = 0; ndone = 0; ncmd = 0; bad = 0; other = 0;
        c_npush = -1; cyc = 0;
        while (cyc < 400) begin
            @(negedge sys_clk);
            req[n] = 1'b1; rw[n] = r; bl_v[n] = b; addr_v[n] = a;
            wd_v[n] = base + 32'(widx); wm_v[n] = widx[3:0];
            wr_full = (wr_stall_at == npush) && (wst < wr_stall_len);
            if (wr_full) wst++;
            cmd_full = (cst < cmd_stall_len) && (r || npush == int'(b) + 1);
            if (cmd_full) cst++;
            rd_empty = !(cmd_seen && ridx <= int'(b)) || (rd_toggle && (cyc % 2 == 1));
            prd = 32'hD000_0000 + 32'(ridx);
            #1;
            if (p_if.wr_en) begin
                if (wr_full) bad++;
                if (npush < 64) begin wlog[npush] = p_if.wr_data; mlog[npush] = p_if.wr_mask; end
                npush++;
            end
            if (ack[n]) begin if (wr_full) bad++; nack++; widx++; end
            if (p_if.cmd_en) begin
                if (cmd_full) bad++;
                ncmd++; c_instr = p_if.cmd_instr; c_bl = p_if.cmd_bl;
                c_addr = p_if.cmd_byte_addr; c_owner = owner; c_npush = npush;
                cmd_seen = 1'b1;
            end
            if (p_if.rd_en) begin if (rd_empty) bad++; ridx++; end
            if (rdv[n]) begin if (nrd < 64) rlog[nrd] = rd_data; nrd++; end
            if (ack[1-n] || rdv[1-n] || done[1-n]) other++;
            if (done[n]) begin ndone++; break; end
            cyc++;
        end
        @(negedge sys_clk);
        req[n] = 1'b0; wr_full = 1'b0; cmd_full = 1'b0; rd_empty = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #1;
        n_run++; if ({p_if.cmd_en, p_if.wr_en, p_if.rd_en} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got=%b exp=000", {p_if.cmd_en, p_if.wr_en, p_if.rd_en}); end
        n_run++; if ({ack, rdv, done} !== 6'b0) begin n_fail++; $display("FAIL reset_req_strobes got=%b exp=0", {ack, rdv, done}); end
        n_run++; if (owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner got=%b exp=0", owner); end
        n_run++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        n_run++; if (p_if.cmd_instr !== 3'b000) begin n_fail++; $display("FAIL reset_instr got=%b exp=000", p_if.cmd_instr); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_calib_gate();
        int hits = 0, seen_at = -1;
        calib_done = 1'b0;
        req[0] = 1'b1; rw[0] = 1'b0; bl_v[0] = 6'd0; addr_v[0] = 30'h40; wd_v[0] = 32'h55; wm_v[0] = 4'h0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk); #1;
            if (p_if.cmd_en || p_if.wr_en) hits++;
        end
        n_run++; if (hits !== 0) begin n_fail++; $display("FAIL calib_gate strobes got=%0d exp=0", hits); end
        @(negedge sys_clk);
        calib_done = 1'b1;
        for (int k = 0; k < 2 && seen_at < 0; k++) begin
            if (k > 0) @(negedge sys_clk);
            #1;
            if (p_if.wr_en) seen_at = k;
        end
        n_run++; if (seen_at < 0) begin n_fail++; $display("FAIL calib_grant got=none exp=within 2 cycles"); end
        run_txn(0, 1'b0, 6'd0, 30'h40, 32'h55);
        n_run++; if (ndone !== 1 || ncmd !== 1) begin n_fail++; $display("FAIL calib_complete got done=%0d cmd=%0d exp=1/1", ndone, ncmd); end
        n_run++; if (c_addr !== 30'h40) begin n_fail++; $display("FAIL calib_addr got=%h exp=40", c_addr); end
    endtask

    task automatic test_write_burst();
        run_txn(1, 1'b0, 6'd3, 30'h100, 32'hA0);
        n_run++; if (npush !== 4) begin n_fail++; $display("FAIL wr_npush got=%0d exp=4", npush); end
        for (int i = 0; i < 4; i++) begin
            n_run++; if (wlog[i] !== 32'hA0 + 32'(i) || mlog[i] !== 4'(i)) begin n_fail++; $display("FAIL wr_word%0d got=%h/%h exp=%h/%h", i, wlog[i], mlog[i], 32'hA0 + 32'(i), 4'(i)); end
        end
        n_run++; if (ncmd !== 1 || c_npush !== 4) begin n_fail++; $display("FAIL wr_cmd_count got=%0d at=%0d exp=1 at 4", ncmd, c_npush); end
        n_run++; if ({c_instr, c_bl, c_addr} !== {3'b000, 6'd3, 30'h100}) begin n_fail++; $display("FAIL wr_cmd_fields got=%b/%0d/%h exp=000/3/100", c_instr, c_bl, c_addr); end
        n_run++; if (c_owner !== 1'b1) begin n_fail++; $display("FAIL wr_owner got=%b exp=1", c_owner); end
        n_run++; if (ndone !== 1 || other !== 0 || bad !== 0) begin n_fail++; $display("FAIL wr_done got done=%0d other=%0d bad=%0d exp=1/0/0", ndone, other, bad); end
    endtask

    task automatic test_read_backpressure();
        rd_toggle = 1'b1;
        run_txn(0, 1'b1, 6'd7, 30'h200, 32'h0);
        rd_toggle = 1'b0;
        n_run++; if (nrd !== 8) begin n_fail++; $display("FAIL rd_count got=%0d exp=8", nrd); end
        for (int i = 0; i < 8; i++) begin
            n_run++; if (rlog[i] !== 32'hD000_0000 + 32'(i)) begin n_fail++; $display("FAIL rd_word%0d got=%h exp=%h", i, rlog[i], 32'hD000_0000 + 32'(i)); end
        end
        n_run++; if ({c_instr, c_bl, c_addr} !== {3'b001, 6'd7, 30'h200}) begin n_fail++; $display("FAIL rd_cmd_fields got=%b/%0d/%h exp=001/7/200", c_instr, c_bl, c_addr); end
        n_run++; if (ndone !== 1 || other !== 0 || bad !== 0 || ncmd !== 1) begin n_fail++; $display("FAIL rd_done got done=%0d other=%0d bad=%0d cmd=%0d exp=1/0/0/1", ndone, other, bad, ncmd); end
    endtask

    task automatic test_full_stall();
        wr_stall_at = 3; wr_stall_len = 5; cmd_stall_len = 4;
        run_txn(0, 1'b0, 6'd7, 30'h300, 32'hB0);
        wr_stall_at = -1; wr_stall_len = 0; cmd_stall_len = 0;
        n_run++; if (npush !== 8 || nack !== 8) begin n_fail++; $display("FAIL stall_count got push=%0d ack=%0d exp=8/8", npush, nack); end
        for (int i = 0; i < 8; i++) begin
            n_run++; if (wlog[i] !== 32'hB0 + 32'(i)) begin n_fail++; $display("FAIL stall_word%0d got=%h exp=%h", i, wlog[i], 32'hB0 + 32'(i)); end
        end
        n_run++; if (bad !== 0 || ncmd !== 1) begin n_fail++; $display("FAIL stall_full_respect got bad=%0d cmd=%0d exp=0/1", bad, ncmd); end
        // grant@0, push 1-3, stall 4-8, push 9-13, cmd_full 14-17, cmd 18, done 19
        n_run++; if (cyc !== 19 || ndone !== 1) begin n_fail++; $display("FAIL stall_timing got cyc=%0d done=%0d exp=19/1", cyc, ndone); end
    endtask

    task automatic test_boundary();
        run_txn(1, 1'b0, 6'd63, 30'h1000, 32'h0);
        n_run++; if (npush !== 64 || wlog[0] !== 32'd0 || wlog[63] !== 32'd63) begin n_fail++; $display("FAIL bl63_push got n=%0d first=%h last=%h exp=64/0/3f", npush, wlog[0], wlog[63]); end
        n_run++; if (ncmd !== 1 || c_bl !== 6'd63 || cyc !== 66) begin n_fail++; $display("FAIL bl63_cmd got cmd=%0d bl=%0d cyc=%0d exp=1/63/66", ncmd, c_bl, cyc); end
        run_txn(1, 1'b1, 6'd0, 30'h8, 32'h0);
        n_run++; if (nrd !== 1 || rlog[0] !== 32'hD000_0000 || ndone !== 1) begin n_fail++; $display("FAIL bl0_read got n=%0d data=%h done=%0d exp=1/d0000000/1", nrd, rlog[0], ndone); end
    endtask

    task automatic test_contention();
        logic seq [4];
        int nd = 0, onehot_bad = 0;
        logic exp_w;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin rw[i] = 1'b0; bl_v[i] = 6'd0; addr_v[i] = 30'h20; wd_v[i] = 32'h1; wm_v[i] = 4'h0; end
        for (int c = 0; c < 60 && nd < 4; c++) begin
            @(negedge sys_clk);
            req = 2'b11;
            #1;
            if (done == 2'b11) onehot_bad++;
            if (done != 2'b00) begin seq[nd] = done[1]; nd++; end
        end
        @(negedge sys_clk);
        req = 2'b00;
        @(negedge sys_clk);
        n_run++; if (nd !== 4 || onehot_bad !== 0) begin n_fail++; $display("FAIL cont_count got=%0d bad=%0d exp=4/0", nd, onehot_bad); end
        for (int i = 0; i < 4 && i < nd; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_w = 1'(i % 2);
`else
            exp_w = 1'b0;
`endif
            n_run++; if (seq[i] !== exp_w) begin n_fail++; $display("FAIL cont_grant%0d got=%b exp=%b", i, seq[i], exp_w); end
        end
    endtask

    task automatic test_reset_mid_read();
        int got = 0, k = 0;
        req[1] = 1'b1; rw[1] = 1'b1; bl_v[1] = 6'd7; addr_v[1] = 30'h400;
        cmd_full = 1'b0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            @(negedge sys_clk);
            rd_empty = 1'b0; prd = 32'hD100_0000 + 32'(k);
            #1;
            if (p_if.rd_en) k++;
            if (rdv[1]) got++;
        end
        n_run++; if (got !== 3 || p_if.rd_en !== 1'b1 || owner !== 1'b1) begin n_fail++; $display("FAIL mid_pre got rdv=%0d rd_en=%b owner=%b exp=3/1/1", got, p_if.rd_en, owner); end
        sys_rst_n = 1'b0;
        #1;
        n_run++; if (p_if.rd_en !== 1'b0 || rdv !== 2'b00) begin n_fail++; $display("FAIL mid_rst_rd got rd_en=%b rdv=%b exp=0/00", p_if.rd_en, rdv); end
        n_run++; if (owner !== 1'b0 || rd_data !== 32'h0 || p_if.cmd_instr !== 3'b000) begin n_fail++; $display("FAIL mid_rst_regs got owner=%b data=%h instr=%b exp=0/0/000", owner, rd_data, p_if.cmd_instr); end
        req[1] = 1'b0; rd_empty = 1'b1;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk); #1;
        n_run++; if ({p_if.cmd_en, p_if.wr_en, p_if.rd_en, done} !== 5'b0) begin n_fail++; $display("FAIL mid_idle got=%b exp=0", {p_if.cmd_en, p_if.wr_en, p_if.rd_en, done}); end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin bl_v[i] = '0; addr_v[i] = '0; wd_v[i] = '0; wm_v[i] = '0; end
        test_reset();
        test_calib_gate();
        test_write_burst();
        test_read_backpressure();
        test_full_stall();
        test_boundary();
        test_contention();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
